mult_arbiter: RTL

Round-robin arbiter and two-stage pipeline that shares one instance of the combinational 32-bit signed `mult` datapath (ports a, b, result) between NREQ requesters. Each requester presents operands with a valid/ready handshake. The arbiter grants at most one request per cycle and registers the operands. The product returns two cycles later on a shared result bus, with a per-requester response strobe. It sits between the ALU issue logic and the shared multiplier, so multiple functional units do not each need a multiplier.

---
 rtl/mult_pkg.sv | 38 +++
 rtl/mult.sv | 15 +
 rtl/mult_arbiter_rr_arbiter.sv | 32 +++
 rtl/mult_arbiter.sv | 116 +++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mult_pkg : shared constants and round-robin pick function          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mult_pkg;

   localparam int W_DEFAULT = 32;
   localparam int MAXREQ    = 8;

   typedef struct packed {
      logic       hit;
      logic [2:0] idx;
   } rr_pick_t;

   function automatic int idw(input int nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

   // Scan from last+1 upward with wrap; first valid requester wins.
   function automatic rr_pick_t rr_next(input logic [MAXREQ-1:0] valid,
                                        input logic [2:0]        last,
                                        input int                nreq);
      rr_pick_t pick;
      int       j;
      pick = '0;
      for (int k = 1; k <= MAXREQ; k++) begin
         j = (int'(last) + k) % nreq;
         if (k <= nreq && !pick.hit && valid[j]) begin
            pick.hit = 1'b1;
            pick.idx = 3'(j);
         end
      end
      return pick;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mult.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mult : combinational 32-bit signed multiplier, low 32 bits kept    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mult (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result
);

   assign result = $unsigned($signed(a) * $signed(b));

endmodule
`default_nettype wire

// File: rtl/mult_arbiter_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin grant (pointer held above)  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rr_arbiter
   import mult_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IDW  = 1
) (
   input  logic [NREQ-1:0] valid_i,
   input  logic [IDW-1:0]  last_i,
   output logic [NREQ-1:0] grant_o,
   output logic [IDW-1:0]  idx_o,
   output logic            any_o
);

   logic [MAXREQ-1:0] valid_ext;
   rr_pick_t          pick;

   assign valid_ext = MAXREQ'(valid_i);
   assign pick      = rr_next(valid_ext, 3'(last_i), NREQ);
   assign idx_o     = IDW'(pick.idx);
   assign any_o     = pick.hit;

   for (genvar i = 0; i < NREQ; i++) begin : g_grant
      assign grant_o[i] = pick.hit && (pick.idx == 3'(i));
   end

endmodule
`default_nettype wire

// File: rtl/mult_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mult_arbiter : round-robin sharing of one multiplier, 2-stage pipe |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mult_arbiter
   import mult_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int W    = W_DEFAULT,
   parameter int CNTW = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [W-1:0]      rsp_result,
   output logic              busy,
   output logic [CNTW-1:0]   ops_done
);

   localparam int IDW = idw(NREQ);

   logic [NREQ-1:0] req_gated;
   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  gnt_idx;
   logic            gnt_any;
   logic [W-1:0]    prod;

   logic [IDW-1:0]  last_q,       last_d;
   logic            s1_v_q,       s1_v_d;
   logic [W-1:0]    s1_a_q,       s1_a_d;
   logic [W-1:0]    s1_b_q,       s1_b_d;
   logic [IDW-1:0]  s1_id_q,      s1_id_d;
   logic [NREQ-1:0] rsp_valid_q,  rsp_valid_d;
   logic [W-1:0]    rsp_result_q, rsp_result_d;
   logic [CNTW-1:0] ops_done_q,   ops_done_d;

   // Reset also masks grants so no handshake is reported in a reset cycle.
   assign req_gated = (en && !rst) ? req_valid : '0;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr (
      .valid_i (req_gated),
      .last_i  (last_q),
      .grant_o (gnt),
      .idx_o   (gnt_idx),
      .any_o   (gnt_any)
   );

   mult u_mult (
      .a      (s1_a_q),
      .b      (s1_b_q),
      .result (prod)
   );

   always_comb begin
      last_d       = last_q;
      s1_v_d       = gnt_any;
      s1_a_d       = s1_a_q;
      s1_b_d       = s1_b_q;
      s1_id_d      = s1_id_q;
      rsp_valid_d  = '0;
      rsp_result_d = rsp_result_q;
      ops_done_d   = ops_done_q;
      if (gnt_any) begin
         s1_a_d  = req_a[int'(gnt_idx)*W +: W];
         s1_b_d  = req_b[int'(gnt_idx)*W +: W];
         s1_id_d = gnt_idx;
         last_d  = gnt_idx;
      end
      if (s1_v_q) begin
         rsp_valid_d[s1_id_q] = 1'b1;
         rsp_result_d         = prod;
         if (ops_done_q != '1) begin
            ops_done_d = ops_done_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q       <= IDW'(NREQ - 1);
         s1_v_q       <= 1'b0;
         s1_a_q       <= '0;
         s1_b_q       <= '0;
         s1_id_q      <= '0;
         rsp_valid_q  <= '0;
         rsp_result_q <= '0;
         ops_done_q   <= '0;
      end else begin
         last_q       <= last_d;
         s1_v_q       <= s1_v_d;
         s1_a_q       <= s1_a_d;
         s1_b_q       <= s1_b_d;
         s1_id_q      <= s1_id_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         ops_done_q   <= ops_done_d;
      end
   end

   assign req_ready  = gnt;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign ops_done   = ops_done_q;
   assign busy       = s1_v_q | (rsp_valid_q != '0);

endmodule
`default_nettype wire
